// File: rtl/stencil_sol_drain.sv
// stencil_sol_drain: captures one packed solution frame and streams it one element per beat.
// Ports: clk, rst (async, active-high); sol_in/sol_valid/sol_ready frame capture handshake;
// out_data/out_valid/out_ready/out_last/out_idx element stream; busy while a frame is held;
// frame_count counts fully drained frames (wrapping).
// Optional: define STENCIL_DRAIN_CHECKSUM_EN to append a checksum beat (sum of elements) to each frame.
module stencil_sol_drain #(
  parameter int DATA_W = 32,
  parameter int NUM_ELEMS = 16,
  parameter int CNT_W = 16,
  localparam int IDX_W = $clog2(NUM_ELEMS + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_W*NUM_ELEMS-1:0] sol_in,
  input  logic                        sol_valid,
  output logic                        sol_ready,
  output logic [DATA_W-1:0]           out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_last,
  output logic [IDX_W-1:0]            out_idx,
  output logic                        busy,
  output logic [CNT_W-1:0]            frame_count
);
`ifdef STENCIL_DRAIN_CHECKSUM_EN
  localparam int LAST = NUM_ELEMS;
`else
  localparam int LAST = NUM_ELEMS - 1;
`endif
  typedef enum logic {IDLE, STREAM} state_t;
  state_t state_q, state_d;
  logic [DATA_W*NUM_ELEMS-1:0] shadow_q, shadow_d;
  logic [IDX_W-1:0] idx_q, idx_d, sel;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] elem, beat;
  logic capture, xfer, last;
  assign capture = state_q == IDLE && sol_valid;
  assign xfer = state_q == STREAM && out_ready;
  assign last = idx_q == IDX_W'(LAST);
  assign elem = shadow_q[DATA_W*int'(sel) +: DATA_W];
`ifdef STENCIL_DRAIN_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q, csum_d;
  logic is_csum;
  assign is_csum = idx_q == IDX_W'(NUM_ELEMS);
  // Keep the element select in range while the checksum beat is on the bus.
  assign sel = is_csum ? '0 : idx_q;
  assign beat = is_csum ? csum_q : elem;
  assign csum_d = capture ? '0 : (xfer && !is_csum) ? csum_q + elem : csum_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) csum_q <= '0;
    else csum_q <= csum_d;
`else
  assign sel = idx_q;
  assign beat = elem;
`endif
  always_comb begin
    state_d = state_q;
    shadow_d = shadow_q;
    idx_d = idx_q;
    cnt_d = cnt_q;
    sol_ready = state_q == IDLE;
    busy = state_q == STREAM;
    out_valid = state_q == STREAM;
    out_last = state_q == STREAM && last;
    out_data = state_q == STREAM ? beat : '0;
    out_idx = idx_q;
    frame_count = cnt_q;
    if (capture) begin
      shadow_d = sol_in;
      idx_d = '0;
      state_d = STREAM;
    end else if (xfer) begin
      idx_d = last ? '0 : idx_q + IDX_W'(1);
      cnt_d = last ? cnt_q + CNT_W'(1) : cnt_q;
      state_d = last ? IDLE : STREAM;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      shadow_q <= '0;
      idx_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      shadow_q <= shadow_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
    end
endmodule

// File: doc/stencil_sol_drain.md
Name: stencil_sol_drain

Overview:
Downstream stage of the 3D stencil compute block. Captures one wide solution frame (NUM_ELEMS packed words) in a single handshake, then serialises it as one word per beat on a valid/ready stream toward memory write-back. Holds a shadow copy of the frame, so the stencil stage can start its next frame as soon as capture completes.

Parameters:
DATA_W, 32, width of one solution element
NUM_ELEMS, 16, elements per frame (frame width = DATA_W*NUM_ELEMS = 512)
CNT_W, 16, width of the completed-frame counter
(localparam IDX_W = $clog2(NUM_ELEMS+1))

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
sol_in  in  DATA_W*NUM_ELEMS  packed solution frame; element e at bits [e*DATA_W +: DATA_W]
sol_valid  in  1  sol_in valid
sol_ready  out  1  drain can accept a frame
out_data  out  DATA_W  streamed element
out_valid  out  1  out_data valid
out_ready  in  1  consumer accepts beat
out_last  out  1  final beat of frame
out_idx  out  IDX_W  index of current beat
busy  out  1  frame held, not fully drained
frame_count  out  CNT_W  frames fully drained, wraps at 2^CNT_W

Behaviour:
- Reset (async): state IDLE, sol_ready=1, out_valid=0, out_last=0, out_data=0, out_idx=0, busy=0, frame_count=0, shadow register=0, checksum accumulator=0.
- States: IDLE, STREAM.
- IDLE: sol_ready=1, busy=0, out_valid=0. On sol_valid&&sol_ready, latch sol_in into shadow, out_idx<=0, go to STREAM. Transition is registered.
- Latency: first beat (element 0) has out_valid=1 in the cycle after capture.
- STREAM: sol_ready=0, busy=1, out_valid=1, out_data=shadow element out_idx.
  - A beat transfers when out_valid&&out_ready.
  - out_data, out_idx and out_last hold stable while out_ready=0.
  - On transfer of a non-last beat, out_idx increments.
  - out_last=1 exactly when out_idx is the final beat index.
- Last-beat transfer: frame_count+1 (mod 2^CNT_W) and return to IDLE. Next cycle out_valid=0 and sol_ready=1. There is no back-to-back overlap, so the minimum frame period is beats+1 cycles.
- sol_valid while in STREAM is ignored: no capture, shadow unchanged. The upstream stage must hold its frame until sol_ready.
- out_ready high while out_valid=0 has no effect.
- NUM_ELEMS=1: the first beat has out_last=1.
- Element order is ascending index, lowest slice first. No arithmetic on data except the optional checksum.
- Reset mid-frame: the partial frame is dropped. frame_count is not incremented, and the block returns to IDLE with all reset values.

Optional Feature:
Macro STENCIL_DRAIN_CHECKSUM_EN.
- Defined:
  - During capture, the accumulator is cleared.
  - Each element beat that transfers adds out_data, mod 2^DATA_W.
  - After element NUM_ELEMS-1, one extra beat is sent: out_idx=NUM_ELEMS, out_data = sum of all NUM_ELEMS elements mod 2^DATA_W.
  - out_last is asserted only on this checksum beat; frame_count increments on its transfer.
- Undefined: no accumulator logic, no extra beat, out_last on element NUM_ELEMS-1, out_idx never exceeds NUM_ELEMS-1.

Test Plan:
- Reset, then idle 5 cycles -> sol_ready=1, out_valid=0, busy=0, frame_count=0.
- Capture frame with element e = 0x100+e, out_ready=1 constantly -> 16 consecutive beats 0x100..0x10F starting 1 cycle after capture. out_last only on idx 15; frame_count=1; sol_ready=1 the cycle after the last beat.
- Same frame with out_ready toggled 1,0,0,1,... -> every element appears exactly once, in order; out_data and out_idx stable during stalls; frame_count=1.
- Second frame (element e = 0xA0+e) presented with sol_valid held high during stream of frame 1 -> no capture until IDLE. Frame 2 streams 0xA0..0xAF intact after frame 1; frame_count=2.
- Assert rst at beat idx 7 of a frame -> out_valid=0 and sol_ready=1 immediately; frame_count unchanged (0). The next frame streams from idx 0.
- With STENCIL_DRAIN_CHECKSUM_EN, frame e = 0xFFFFFFF0+e -> 17 beats. Beat 16 has out_idx=16, out_data=0xFFFFFF78, out_last=1 only on that beat.
